// File: rtl/smpl_pkg.sv
// smpl_pkg: shared definitions for the SMPL data-memory arbiter slice.
//   SMPL_ADDR_W / SMPL_DATA_W : default address / data widths
//   REQ_CORE / REQ_AUX        : requester index constants
//   arb_state_t               : arbiter FSM state encoding
package smpl_pkg;

    localparam int unsigned SMPL_ADDR_W = 13;
    localparam int unsigned SMPL_DATA_W = 16;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/smpl_dmem_arbiter_if.sv
// smpl_dmem_arbiter_if: requester-side and memory-side buses of the arbiter.
//   slave  modport : arbiter view of the two requesters
//                    in  req[2], we[2], addr[2][ADDR_W], wdata[2][DATA_W]
//                    out gnt[2], done[2], rdata[DATA_W]
//   master modport : arbiter view of the memory
//                    out mem_req, mem_we, mem_addr, mem_wdata
//                    in  mem_ack, mem_rdata
interface smpl_dmem_arbiter_if
    import smpl_pkg::*;
#(
    parameter int unsigned ADDR_W = SMPL_ADDR_W,
    parameter int unsigned DATA_W = SMPL_DATA_W
);

    logic [1:0]             req;
    logic [1:0]             we;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             gnt;
    logic [1:0]             done;
    logic [DATA_W-1:0]      rdata;

    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_ack;
    logic [DATA_W-1:0]      mem_rdata;

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

endinterface

// File: rtl/smpl_rr_picker.sv
// smpl_rr_picker: combinational 2-way round-robin winner select.
//   req[2]  in  : request vector (0 = core, 1 = aux)
//   last    in  : index of the requester served most recently
//   winner  out : selected requester index (meaningful only when |req)
module smpl_rr_picker
    import smpl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = REQ_CORE;
        if (req[0] && req[1]) begin
            // Conflict: whoever was not served last goes next.
            winner = ~last;
        end else if (req[1]) begin
            winner = REQ_AUX;
        end
    end

endmodule

// File: rtl/smpl_dmem_arbiter.sv
// smpl_dmem_arbiter: two-requester (core/aux) arbiter in front of a single
// data memory port, one access outstanding at a time.
//   clock        in  : sole clock, rising edge
//   reset        in  : synchronous, active-high
//   rq  (slave)      : requester handshake (req/we/addr/wdata -> gnt/done/rdata)
//   mem (master)     : memory handshake (mem_req/we/addr/wdata -> mem_ack/rdata)
module smpl_dmem_arbiter
    import smpl_pkg::*;
#(
    parameter int unsigned ADDR_W = SMPL_ADDR_W,
    parameter int unsigned DATA_W = SMPL_DATA_W
) (
    input  logic                 clock,
    input  logic                 reset,
    smpl_dmem_arbiter_if.slave   rq,
    smpl_dmem_arbiter_if.master  mem
);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              winner;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              mem_req;
    logic [DATA_W-1:0] rdata;

    smpl_rr_picker u_picker (
        .req    (rq.req),
        .last   (last_q),
        .winner (winner)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt     = '0;
        done    = '0;
        mem_req = 1'b0;
        rdata   = rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (|rq.req) begin
                    gnt[winner] = 1'b1;
                    owner_d     = winner;
                    we_d        = rq.we[winner];
                    addr_d      = rq.addr[winner];
                    wdata_d     = rq.wdata[winner];
                    last_d      = winner;
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                mem_req = 1'b1;
                if (mem.mem_ack) begin
                    done[owner_q] = 1'b1;
                    // Reads forward memory data in the done cycle and keep it;
                    // writes leave the last read value on rdata.
                    if (!we_q) begin
                        rdata   = mem.mem_rdata;
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Reset abandons whatever is in flight: no handshake pulses leak out
        // during the reset cycle itself.
        if (reset) begin
            gnt     = '0;
            done    = '0;
            mem_req = 1'b0;
            rdata   = rdata_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            last_q  <= REQ_AUX;
            owner_q <= REQ_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rq.gnt        = gnt;
    assign rq.done       = done;
    assign rq.rdata      = rdata;
    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_req & we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_smpl_dmem_arbiter.sv
// tb_smpl_dmem_arbiter: directed scenarios with literal expectations, then
// randomized requester/memory traffic, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_smpl_dmem_arbiter;
    import smpl_pkg::*;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    smpl_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    smpl_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .rq    (bus),
        .mem   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic          who;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    bit            m_valid = 1'b0;
    bit            m_busy;
    logic          m_last;
    logic [DW-1:0] m_rdata;
    txn_t          m_cur;

    always @(negedge clock) begin
        logic [1:0]    eg;
        logic [1:0]    ed;
        logic          emr;
        logic [DW-1:0] erd;
        logic          w;
        eg  = 2'b00;
        ed  = 2'b00;
        emr = 1'b0;
        erd = m_rdata;
        if (reset) begin
            if (m_valid) begin
                chk("m_rst_gnt",   32'(bus.gnt),     32'(eg));
                chk("m_rst_done",  32'(bus.done),    32'(ed));
                chk("m_rst_mreq",  32'(bus.mem_req), 32'(emr));
                chk("m_rst_rdata", 32'(bus.rdata),   32'(erd));
            end
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_last  = REQ_AUX;
            m_rdata = '0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (bus.req != 2'b00) begin
                    // Lone requester wins; on conflict the one not served last.
                    w = (bus.req == 2'b11) ? ~m_last : bus.req[1];
                    eg[w]       = 1'b1;
                    m_cur.who   = w;
                    m_cur.we    = bus.we[w];
                    m_cur.addr  = bus.addr[w];
                    m_cur.wdata = bus.wdata[w];
                    m_last      = w;
                    m_busy      = 1'b1;
                end
            end else begin
                emr = 1'b1;
                chk("m_mem_we",    32'(bus.mem_we),    32'(m_cur.we));
                chk("m_mem_addr",  32'(bus.mem_addr),  32'(m_cur.addr));
                chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(m_cur.wdata));
                if (bus.mem_ack) begin
                    ed[m_cur.who] = 1'b1;
                    if (!m_cur.we) begin
                        erd     = bus.mem_rdata;
                        m_rdata = bus.mem_rdata;
                    end
                    m_busy = 1'b0;
                end
            end
            chk("m_gnt",   32'(bus.gnt),     32'(eg));
            chk("m_done",  32'(bus.done),    32'(ed));
            chk("m_mreq",  32'(bus.mem_req), 32'(emr));
            chk("m_rdata", 32'(bus.rdata),   32'(erd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    logic [1:0] obs_gnt;
    logic       obs_mr;
    int         wait_cnt;

    initial begin
        reset         = 1'b1;
        bus.req       = '0;
        bus.we        = '0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Core read, memory answers two cycles after mem_req rises.
        bus.req = 2'b01; bus.we[0] = 1'b0; bus.addr[0] = 13'h005;
        settle(); chk("t1_gnt", 32'(bus.gnt), 32'h1);
        tick(); bus.req = 2'b00;
        settle(); chk("t1_mreq", 32'(bus.mem_req), 32'h1);
                  chk("t1_maddr", 32'(bus.mem_addr), 32'h005);
                  chk("t1_mwe", 32'(bus.mem_we), 32'h0);
        tick();
        settle(); chk("t1_wait_done", 32'(bus.done), 32'h0);
        tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
        settle(); chk("t1_done", 32'(bus.done), 32'h1);
                  chk("t1_rdata", 32'(bus.rdata), 32'hBEEF);
        tick(); bus.mem_ack = 1'b0;
        settle(); chk("t1_mreq_drop", 32'(bus.mem_req), 32'h0);
                  chk("t1_rdata_hold", 32'(bus.rdata), 32'hBEEF);

        // Conflict straight after reset: core write first, then aux read.
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        bus.req = 2'b11; bus.we = 2'b01;
        bus.addr[0] = 13'h0010; bus.wdata[0] = 16'h1234; bus.addr[1] = 13'h0011;
        settle(); chk("t2_gnt_core", 32'(bus.gnt), 32'h1);
        tick(); bus.req = 2'b10; bus.mem_ack = 1'b1;
        settle(); chk("t2_wr_we", 32'(bus.mem_we), 32'h1);
                  chk("t2_wr_addr", 32'(bus.mem_addr), 32'h0010);
                  chk("t2_wr_data", 32'(bus.mem_wdata), 32'h1234);
                  chk("t2_done_core", 32'(bus.done), 32'h1);
        tick(); bus.mem_ack = 1'b0;
        settle(); chk("t2_idle_gap", 32'(bus.mem_req), 32'h0);
                  chk("t2_gnt_aux", 32'(bus.gnt), 32'h2);
        tick(); bus.req = 2'b00; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A;
        settle(); chk("t2_rd_addr", 32'(bus.mem_addr), 32'h0011);
                  chk("t2_rd_we", 32'(bus.mem_we), 32'h0);
                  chk("t2_done_aux", 32'(bus.done), 32'h2);
                  chk("t2_rdata", 32'(bus.rdata), 32'h5A5A);
        tick(); bus.mem_ack = 1'b0;

        // Both requesting continuously, latency 1: grants alternate.
        bus.req = 2'b11; bus.we = 2'b00;
        for (int k = 0; k < 4; k++) begin
            settle(); chk("t3_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
                      chk("t3_gap", 32'(bus.mem_req), 32'h0);
            tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 16'(k + 16'h100);
            settle(); chk("t3_mreq", 32'(bus.mem_req), 32'h1);
                      chk("t3_done", 32'(bus.done), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick(); bus.mem_ack = 1'b0;
        end
        bus.req = 2'b00;

        // Waiting aux changes its fields while core's write is in flight.
        bus.req = 2'b01; bus.we = 2'b01; bus.addr[0] = 13'h100; bus.wdata[0] = 16'hAAAA;
        settle(); chk("t4_gnt_core", 32'(bus.gnt), 32'h1);
        tick(); bus.req = 2'b10; bus.we[1] = 1'b0; bus.addr[1] = 13'h1FF;
        settle(); chk("t4_addr_held0", 32'(bus.mem_addr), 32'h100);
        tick(); bus.we[1] = 1'b1; bus.addr[1] = 13'h0AA; bus.wdata[1] = 16'h5555;
        settle(); chk("t4_addr_held1", 32'(bus.mem_addr), 32'h100);
                  chk("t4_wdata_held", 32'(bus.mem_wdata), 32'hAAAA);
        tick(); bus.mem_ack = 1'b1;
        settle(); chk("t4_done_core", 32'(bus.done), 32'h1);
        tick(); bus.mem_ack = 1'b0;
        settle(); chk("t4_gnt_aux", 32'(bus.gnt), 32'h2);
        tick(); bus.req = 2'b00;
        settle(); chk("t4_aux_addr", 32'(bus.mem_addr), 32'h0AA);
                  chk("t4_aux_wdata", 32'(bus.mem_wdata), 32'h5555);
        tick(); bus.mem_ack = 1'b1;
        settle(); chk("t4_done_aux", 32'(bus.done), 32'h2);
        tick(); bus.mem_ack = 1'b0;

        // Reset while busy, then a stale mem_ack.
        bus.req = 2'b01; bus.we = 2'b00; bus.addr[0] = 13'h007;
        settle(); chk("t5_gnt", 32'(bus.gnt), 32'h1);
        tick(); bus.req = 2'b00; reset = 1'b1;
        settle(); chk("t5_rst_mreq", 32'(bus.mem_req), 32'h0);
        tick(); reset = 1'b0; bus.mem_ack = 1'b1;
        settle(); chk("t5_stale_done", 32'(bus.done), 32'h0);
                  chk("t5_stale_mreq", 32'(bus.mem_req), 32'h0);
        tick(); bus.mem_ack = 1'b0; bus.req = 2'b11;
        settle(); chk("t5_gnt_core", 32'(bus.gnt), 32'h1);
        tick(); bus.req = 2'b00; bus.mem_ack = 1'b1;
        settle();
        tick(); bus.mem_ack = 1'b0;

        // Spurious mem_ack while idle.
        bus.mem_ack = 1'b1;
        settle(); chk("t6_done", 32'(bus.done), 32'h0);
                  chk("t6_mreq", 32'(bus.mem_req), 32'h0);
        tick(); bus.mem_ack = 1'b0;
        settle(); chk("t6_after_mreq", 32'(bus.mem_req), 32'h0);
                  chk("t6_after_gnt", 32'(bus.gnt), 32'h0);

        // Randomized traffic; every cycle is checked by the model above.
        obs_gnt  = 2'b00;
        obs_mr   = 1'b0;
        wait_cnt = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 99) == 0) reset = 1'b1;

            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = -1;
            end else if (obs_mr) begin
                if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = DW'($urandom);
                    wait_cnt      = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
                if ($urandom_range(0, 19) == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = DW'($urandom);
                end
            end

            for (int i = 0; i < 2; i++) begin
                if (obs_gnt[i] || (!bus.req[i] && $urandom_range(0, 2) == 0)) begin
                    if (!obs_gnt[i] || $urandom_range(0, 1) == 1) begin
                        bus.req[i]   = 1'b1;
                        bus.we[i]    = 1'($urandom);
                        bus.addr[i]  = AW'($urandom);
                        bus.wdata[i] = DW'($urandom);
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end else if (bus.req[i] && obs_mr && $urandom_range(0, 3) == 0) begin
                    bus.addr[i]  = AW'($urandom);
                    bus.wdata[i] = DW'($urandom);
                end
            end

            settle();
            obs_gnt = bus.gnt;
            obs_mr  = bus.mem_req;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
